uart_pic_frame_parser: RTL and testbench

- Sits between uart_rx and lcd_show_pic.
- Takes the raw received UART byte stream and parses framed picture updates: sync, window header, RGB565 payload, checksum.
- Emits one window descriptor per frame, then a buffered stream of 16-bit pixels over a valid/ready handshake.
- Detects format, range, overflow, timeout and checksum errors.

---
 rtl/lcd_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_pic_frame_parser.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_pic_frame_parser.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD picture path: parser state encoding,
// error codes and the default panel geometry.
package lcd_pkg;

    localparam int H_RES_DEF = 240;
    localparam int V_RES_DEF = 320;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_HDR    = 3'd2,
        ST_CHECK  = 3'd3,
        ST_PIX_HI = 3'd4,
        ST_PIX_LO = 3'd5,
        ST_CSUM   = 3'd6
    } parser_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_SYNC    = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_CSUM    = 3'd5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A write into a full FIFO is
// accepted only when a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    // Head word is presented directly; forced to zero when nothing is buffered.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_pic_frame_parser.sv
// Parses framed picture updates from a UART byte stream into a window
// descriptor and a buffered RGB565 pixel stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | hunting for SYNC0, other bytes dropped silently
// ST_SYNC   | SYNC0 seen, expecting SYNC1 (repeated SYNC0 tolerated)
// ST_HDR    | collecting 8 header bytes x0,y0,w,h (big-endian)
// ST_CHECK  | one-cycle window range check, no byte consumed
// ST_PIX_HI | waiting for pixel high byte
// ST_PIX_LO | waiting for pixel low byte, pushes pixel to FIFO
// ST_CSUM   | waiting for XOR checksum byte
module uart_pic_frame_parser
    import lcd_pkg::*;
#(
    parameter int          H_RES       = H_RES_DEF,
    parameter int          V_RES       = V_RES_DEF,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [23:0] TIMEOUT_CYC = 24'd600_000,
    parameter logic [7:0]  SYNC0       = 8'hA5,
    parameter logic [7:0]  SYNC1       = 8'h5A
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [8:0]  win_x,
    output logic [8:0]  win_y,
    output logic [8:0]  win_w,
    output logic [8:0]  win_h,
    output logic        win_valid,
    output logic [15:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        frame_done,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);

    parser_state_t state;
    parser_state_t state_nxt;

    logic [2:0]  hdr_cnt;
    logic [63:0] hdr_sr;
    logic [7:0]  csum;
    logic [7:0]  pix_hi_q;
    logic [16:0] pix_left;
    logic [23:0] gap_left;
    logic [8:0]  win_x_q;
    logic [8:0]  win_y_q;
    logic [8:0]  win_w_q;
    logic [8:0]  win_h_q;

    logic [15:0] hdr_x;
    logic [15:0] hdr_y;
    logic [15:0] hdr_w;
    logic [15:0] hdr_h;
    logic        upper_bad;
    logic [9:0]  x_end;
    logic [9:0]  y_end;
    logic        range_ok;
    logic [16:0] area;

    logic        gap_run;
    logic        timeout_hit;
    logic        win_pass;
    logic        done_set;
    logic        err_set;
    logic [2:0]  err_val;

    logic        fifo_wr;
    logic        fifo_rd;
    logic        fifo_full;
    logic        fifo_empty;
    logic [15:0] fifo_din;

    // Header fields sit in a byte shift register, first byte at the top.
    assign hdr_x = hdr_sr[63:48];
    assign hdr_y = hdr_sr[47:32];
    assign hdr_w = hdr_sr[31:16];
    assign hdr_h = hdr_sr[15:0];

    assign upper_bad = (|hdr_x[15:9]) || (|hdr_y[15:9]) || (|hdr_w[15:9]) || (|hdr_h[15:9]);
    assign x_end     = {1'b0, hdr_x[8:0]} + {1'b0, hdr_w[8:0]};
    assign y_end     = {1'b0, hdr_y[8:0]} + {1'b0, hdr_h[8:0]};
    assign range_ok  = !upper_bad && (hdr_w[8:0] != 9'd0) && (hdr_h[8:0] != 9'd0) &&
                       (x_end <= 10'(H_RES)) && (y_end <= 10'(V_RES));
    // Range-checked window is at most 240x320, which fits in 17 bits.
    assign area      = 17'(hdr_w[8:0]) * 17'(hdr_h[8:0]);

    assign gap_run     = state inside {ST_SYNC, ST_HDR, ST_PIX_HI, ST_PIX_LO, ST_CSUM};
    assign timeout_hit = gap_run && !rx_valid && (gap_left == 24'd1);

    assign fifo_din = {pix_hi_q, rx_byte};
    assign fifo_rd  = px_ready && !fifo_empty;
    assign px_valid = !fifo_empty;
    assign busy     = (state != ST_IDLE);

    // Descriptor pulses in the CHECK cycle itself, so the live header is bypassed out.
    assign win_valid = win_pass;
    assign win_x     = win_pass ? hdr_x[8:0] : win_x_q;
    assign win_y     = win_pass ? hdr_y[8:0] : win_y_q;
    assign win_w     = win_pass ? hdr_w[8:0] : win_w_q;
    assign win_h     = win_pass ? hdr_h[8:0] : win_h_q;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_px_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (fifo_rd),
        .rd_data (px_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        fifo_wr   = 1'b0;
        win_pass  = 1'b0;
        done_set  = 1'b0;
        err_set   = 1'b0;
        err_val   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_byte == SYNC0) state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (rx_valid) begin
                    if (rx_byte == SYNC1) begin
                        state_nxt = ST_HDR;
                    end else if (rx_byte != SYNC0) begin
                        err_set   = 1'b1;
                        err_val   = ERR_SYNC;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_HDR: begin
                if (rx_valid && hdr_cnt == 3'd7) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (range_ok) begin
                    win_pass  = 1'b1;
                    state_nxt = ST_PIX_HI;
                end else begin
                    err_set   = 1'b1;
                    err_val   = ERR_RANGE;
                    state_nxt = ST_IDLE;
                end
            end
            ST_PIX_HI: begin
                if (rx_valid) state_nxt = ST_PIX_LO;
            end
            ST_PIX_LO: begin
                if (rx_valid) begin
                    if (fifo_full && !fifo_rd) begin
                        err_set   = 1'b1;
                        err_val   = ERR_OVERFLOW;
                        state_nxt = ST_IDLE;
                    end else begin
                        fifo_wr   = 1'b1;
                        state_nxt = (pix_left == 17'd1) ? ST_CSUM : ST_PIX_HI;
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum) begin
                        done_set = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        err_val = ERR_CSUM;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Timeout only fires on byte-free cycles, so it never collides with the above.
        if (timeout_hit) begin
            err_set   = 1'b1;
            err_val   = ERR_TIMEOUT;
            state_nxt = ST_IDLE;
        end
    end

    // Datapath: header capture, checksum, pixel countdown, gap timer, status pulses.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            hdr_cnt    <= '0;
            hdr_sr     <= '0;
            csum       <= '0;
            pix_hi_q   <= '0;
            pix_left   <= '0;
            gap_left   <= '0;
            win_x_q    <= '0;
            win_y_q    <= '0;
            win_w_q    <= '0;
            win_h_q    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            frame_done <= done_set;
            frame_err  <= err_set;
            if (err_set) err_code <= err_val;

            if (rx_valid || !gap_run) gap_left <= TIMEOUT_CYC;
            else                      gap_left <= gap_left - 24'd1;

            if (state == ST_HDR) begin
                if (rx_valid) begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                    hdr_sr  <= {hdr_sr[55:0], rx_byte};
                end
            end else begin
                hdr_cnt <= '0;
            end

            if (state == ST_SYNC) begin
                csum <= '0;
            end else if (rx_valid && (state inside {ST_HDR, ST_PIX_HI, ST_PIX_LO})) begin
                csum <= csum ^ rx_byte;
            end

            if (state == ST_PIX_HI && rx_valid) pix_hi_q <= rx_byte;

            if (win_pass) begin
                pix_left <= area;
                win_x_q  <= hdr_x[8:0];
                win_y_q  <= hdr_y[8:0];
                win_w_q  <= hdr_w[8:0];
                win_h_q  <= hdr_h[8:0];
            end else if (fifo_wr) begin
                pix_left <= pix_left - 17'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pic_frame_parser.sv
// Directed bench for the UART picture frame parser.
module tb_uart_pic_frame_parser;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [8:0]  win_x, win_y, win_w, win_h;
    logic        win_valid;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        frame_done;
    logic        frame_err;
    logic [2:0]  err_code;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int win_cnt  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [15:0] px_q[$];

    int base_px, base_done, base_err, base_win;

    uart_pic_frame_parser #(
        .TIMEOUT_CYC (24'd200)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .win_w      (win_w),
        .win_h      (win_h),
        .win_valid  (win_valid),
        .px_data    (px_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Pulse counters and pixel capture, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (win_valid)  win_cnt  <= win_cnt + 1;
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if (px_valid && px_ready) px_q.push_back(px_data);
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 2x1 window at origin, pixels F800 and 07E0; XOR of header+payload is 0x1C.
    task automatic send_frame1(input logic [7:0] ck, input string tag);
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
        rx_byte  = 8'h01;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check({tag, " win_valid"}, 32'(win_valid), 32'd1);
        check({tag, " win_x"}, 32'(win_x), 32'd0);
        check({tag, " win_y"}, 32'(win_y), 32'd0);
        check({tag, " win_w"}, 32'(win_w), 32'd2);
        check({tag, " win_h"}, 32'(win_h), 32'd1);
        tick();
        send_byte(8'hF8); send_byte(8'h00);
        send_byte(8'h07); send_byte(8'hE0);
        send_byte(ck);
        repeat (3) tick();
    endtask

    initial begin
        sys_rst_n = 1'b0;
        rx_byte   = 8'h00;
        rx_valid  = 1'b0;
        px_ready  = 1'b1;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        tick();

        // Reset state
        check("rst win_valid", 32'(win_valid), 32'd0);
        check("rst win_w", 32'(win_w), 32'd0);
        check("rst px_valid", 32'(px_valid), 32'd0);
        check("rst px_data", 32'(px_data), 32'd0);
        check("rst frame_err", 32'(frame_err), 32'd0);
        check("rst err_code", 32'(err_code), 32'd0);
        check("rst busy", 32'(busy), 32'd0);

        // Good frame, consumer always ready
        base_px = px_q.size(); base_done = done_cnt; base_err = err_cnt;
        send_frame1(8'h1C, "f1");
        check("f1 done pulses", 32'(done_cnt - base_done), 32'd1);
        check("f1 err pulses", 32'(err_cnt - base_err), 32'd0);
        check("f1 px count", 32'(px_q.size() - base_px), 32'd2);
        if (px_q.size() >= base_px + 2) begin
            check("f1 px0", 32'(px_q[base_px]), 32'h0000_F800);
            check("f1 px1", 32'(px_q[base_px+1]), 32'h0000_07E0);
        end
        check("f1 err_code", 32'(err_code), 32'd0);
        check("f1 busy", 32'(busy), 32'd0);
        check("f1 win_w held", 32'(win_w), 32'd2);

        // Same frame with a bad checksum
        base_px = px_q.size(); base_done = done_cnt; base_err = err_cnt;
        send_frame1(8'h00, "f2");
        check("f2 px count", 32'(px_q.size() - base_px), 32'd2);
        check("f2 done pulses", 32'(done_cnt - base_done), 32'd0);
        check("f2 err pulses", 32'(err_cnt - base_err), 32'd1);
        check("f2 err_code", 32'(err_code), 32'd5);
        check("f2 busy", 32'(busy), 32'd0);

        // x0=239, w=2 overruns the panel width
        base_win = win_cnt; base_err = err_cnt; base_done = done_cnt;
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'hEF); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        repeat (3) tick();
        check("rng win pulses", 32'(win_cnt - base_win), 32'd0);
        check("rng err pulses", 32'(err_cnt - base_err), 32'd1);
        check("rng err_code", 32'(err_code), 32'd2);
        check("rng busy", 32'(busy), 32'd0);
        send_frame1(8'h1C, "rng_next");
        check("rng next done", 32'(done_cnt - base_done), 32'd1);

        // 4x5 window exactly touching the bottom-right corner, consumer stalled
        px_ready = 1'b0;
        base_px = px_q.size(); base_err = err_cnt; base_done = done_cnt;
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'hEC); send_byte(8'h01); send_byte(8'h3B);
        send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
        rx_byte  = 8'h05;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("ovf win_valid", 32'(win_valid), 32'd1);
        check("ovf win_x", 32'(win_x), 32'h0EC);
        check("ovf win_y", 32'(win_y), 32'h13B);
        check("ovf win_w", 32'(win_w), 32'd4);
        check("ovf win_h", 32'(win_h), 32'd5);
        tick();
        send_byte(8'h01);
        check("ovf px_valid before lo", 32'(px_valid), 32'd0);
        rx_byte  = 8'h00;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        check("ovf px_valid latency", 32'(px_valid), 32'd1);
        check("ovf px_data head", 32'(px_data), 32'h0000_0100);
        check("ovf busy mid", 32'(busy), 32'd1);
        tick();
        for (int k = 1; k <= 16; k++) begin
            send_byte(8'h01);
            send_byte(8'(k));
        end
        repeat (3) tick();
        check("ovf err pulses", 32'(err_cnt - base_err), 32'd1);
        check("ovf err_code", 32'(err_code), 32'd3);
        check("ovf busy", 32'(busy), 32'd0);
        check("ovf px_valid kept", 32'(px_valid), 32'd1);
        check("ovf no pop yet", 32'(px_q.size() - base_px), 32'd0);
        px_ready = 1'b1;
        repeat (25) tick();
        check("ovf drained count", 32'(px_q.size() - base_px), 32'd16);
        if (px_q.size() >= base_px + 16) begin
            for (int i = 0; i < 16; i++) begin
                check($sformatf("ovf px%0d", i), 32'(px_q[base_px+i]), 32'h0100 + 32'(i));
            end
        end
        check("ovf empty after drain", 32'(px_valid), 32'd0);
        check("ovf done pulses", 32'(done_cnt - base_done), 32'd0);

        // Stall after five header bytes
        base_err = err_cnt; base_done = done_cnt; base_px = px_q.size();
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00);
        repeat (150) tick();
        check("tmo busy before", 32'(busy), 32'd1);
        check("tmo no err before", 32'(err_cnt - base_err), 32'd0);
        repeat (60) tick();
        check("tmo err pulses", 32'(err_cnt - base_err), 32'd1);
        check("tmo err_code", 32'(err_code), 32'd4);
        check("tmo busy", 32'(busy), 32'd0);
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_frame1(8'h1C, "resync");
        check("resync done", 32'(done_cnt - base_done), 32'd1);
        check("resync px count", 32'(px_q.size() - base_px), 32'd2);
        check("resync err_code held", 32'(err_code), 32'd4);

        // Reset in the middle of the payload
        px_ready = 1'b0;
        base_err = err_cnt; base_done = done_cnt;
        send_byte(8'hA5); send_byte(8'h5A);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hF8); send_byte(8'h00);
        check("mrst px_valid pre", 32'(px_valid), 32'd1);
        check("mrst busy pre", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        check("mrst px_valid", 32'(px_valid), 32'd0);
        check("mrst px_data", 32'(px_data), 32'd0);
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst err_code", 32'(err_code), 32'd0);
        check("mrst win_w", 32'(win_w), 32'd0);
        check("mrst win_h", 32'(win_h), 32'd0);
        check("mrst win_valid", 32'(win_valid), 32'd0);
        check("mrst frame_done", 32'(frame_done), 32'd0);
        check("mrst frame_err", 32'(frame_err), 32'd0);
        repeat (5) tick();
        check("mrst no done", 32'(done_cnt - base_done), 32'd0);
        check("mrst no err", 32'(err_cnt - base_err), 32'd0);
        px_ready = 1'b1;
        base_px = px_q.size();
        send_frame1(8'h1C, "post_rst");
        check("post_rst done", 32'(done_cnt - base_done), 32'd1);
        check("post_rst px count", 32'(px_q.size() - base_px), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
